// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one-outstanding I-mem requests, buffers
// returned words (tagged PC+4) in a prefetch FIFO. Optional counters: FETCH_PERF_CNT_EN.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] InstructionOUT,
    output logic [31:0] PCResultOUT,
    output logic        InstrValid,
    output logic        FlushIFID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a request is presented while IMemReq=1 with IMemAddr held stable;
    // it completes in the cycle IMemAck=1, and IMemData is sampled that same edge.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_after_pop;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic          head_valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic          unused_rpc_lsbs;

    assign unused_rpc_lsbs = ^RedirectPC[1:0];

    always_comb begin
        head_valid      = (count_q != '0);
        pop             = head_valid && !Stall && !Redirect;
        count_after_pop = count_q - CW'(pop);
        push            = (state_q == ST_WAIT) && IMemAck && !Redirect;
        issue           = 1'b0;
        state_d         = state_q;

        case (state_q)
            ST_IDLE: begin
                if (!Redirect && (count_after_pop < DEPTH_C)) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Redirect) begin
                    state_d = IMemAck ? ST_IDLE : ST_DISCARD;
                end else if (IMemAck) begin
                    // Credit counts the entry being pushed this edge.
                    if ((count_after_pop + CW'(1)) < DEPTH_C) begin
                        issue = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (IMemAck) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d    = count_after_pop + CW'(push);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;

        if (issue) begin
            addr_d     = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (Redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = {RedirectPC[31:2], 2'b00};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge Clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= IMemData;
            pc_mem_q[wr_ptr_q]    <= addr_q + 32'd4;
        end
    end

    assign IMemReq        = (state_q != ST_IDLE);
    assign IMemAddr       = addr_q;
    assign InstrValid     = head_valid;
    assign InstructionOUT = head_valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign PCResultOUT    = head_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
    assign FlushIFID      = Redirect;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + (push ? 32'd1 : 32'd0);
        bubble_cnt_d = bubble_cnt_q + ((!head_valid && !Stall) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: vector table for the basic fetch/stall/redirect
// flow, plus hand-written sequences for back-pressure, redirect, PC wrap and reset.
module tb_instr_fetch_queue;

    localparam logic [31:0] XK = 32'hA5A5_A5A5;

    // ---------------- clock / reset / DUT signals ----------------
    logic        clk;
    logic        rst_n;
    logic        stall, redirect, imem_ack;
    logic [31:0] redirect_pc, imem_data;
    logic        imem_req, instr_valid, flush;
    logic [31:0] imem_addr, instr_out, pc_out;

    logic        w_rst_n, w_stall, w_redirect, w_ack;
    logic [31:0] w_rpc, w_data;
    logic        w_req, w_valid, w_flush;
    logic [31:0] w_addr, w_instr, w_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, bubble_count, w_fetch_count, w_bubble_count;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue u_dut (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .Redirect(redirect),
        .RedirectPC(redirect_pc), .IMemReq(imem_req), .IMemAddr(imem_addr),
        .IMemAck(imem_ack), .IMemData(imem_data), .InstructionOUT(instr_out),
        .PCResultOUT(pc_out), .InstrValid(instr_valid), .FlushIFID(flush)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fetch_count), .BubbleCount(bubble_count)
`endif
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .Clk(clk), .Rst_n(w_rst_n), .Stall(w_stall), .Redirect(w_redirect),
        .RedirectPC(w_rpc), .IMemReq(w_req), .IMemAddr(w_addr),
        .IMemAck(w_ack), .IMemData(w_data), .InstructionOUT(w_instr),
        .PCResultOUT(w_pc), .InstrValid(w_valid), .FlushIFID(w_flush)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(w_fetch_count), .BubbleCount(w_bubble_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    logic ack_prev;
    logic seen_bad;
    logic [63:0] exp_q[$];   // {instr, pc+4}

    logic [31:0] w_addr_log[$];
    logic [31:0] w_pc_log[$];
    logic [31:0] w_instr_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_flush;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic st, input logic rd, input logic [31:0] rpc,
                           input logic ak, input logic [31:0] dt,
                           input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_flush);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rpc; v.ack = ak; v.data = dt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_flush = e_flush;
        vq.push_back(v);
    endtask

    // ---------------- driver: auto-acking memory + FIFO model ----------------
    task automatic run_auto(input int n, input logic st);
        for (int c = 0; c < n; c++) begin
            stall    = st;
            redirect = 1'b0;
            imem_ack = ack_prev ? 1'b0 : imem_req;
            imem_data = imem_addr ^ XK;
            ack_prev = imem_ack;
            #2;
            chk("occupancy_le_depth", ((exp_q.size() + int'(imem_req)) <= 4) ? 1 : 0, 1);
            chk("valid_vs_model", instr_valid, (exp_q.size() != 0) ? 1 : 0);
            if (instr_valid && exp_q.size() != 0) begin
                chk("head_instr", instr_out, exp_q[0][63:32]);
                chk("head_pc", pc_out, exp_q[0][31:0]);
                if (!st) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
            if (instr_valid && instr_out == 32'hDEAD_BEEF) seen_bad = 1'b1;
            if (imem_req && imem_ack) exp_q.push_back({imem_data, imem_addr + 32'd4});
            @(posedge clk); #1;
        end
    endtask

    // ---------------- PC-wrap instance, free running ----------------
    initial begin
        w_rst_n = 1'b0; w_stall = 1'b0; w_redirect = 1'b0; w_rpc = '0;
        w_ack = 1'b0; w_data = '0;
        repeat (2) @(posedge clk);
        #1 w_rst_n = 1'b1;
        repeat (30) begin
            if (w_valid && w_pc_log.size() < 8) begin
                w_pc_log.push_back(w_pc);
                w_instr_log.push_back(w_instr);
            end
            w_ack  = w_ack ? 1'b0 : w_req;
            w_data = w_addr ^ XK;
            if (w_ack && w_req && w_addr_log.size() < 8) w_addr_log.push_back(w_addr);
            @(posedge clk); #1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        logic found;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_data = '0; ack_prev = 1'b0; seen_bad = 1'b0;

        // Basic fetch, stall with push, redirect from WAIT into DISCARD.
        add_vec(0,0,32'h0,  0,32'h0,        0,32'h000,0,32'h0,        32'h00,0);
        add_vec(0,0,32'h0,  0,32'h0,        1,32'h000,0,32'h0,        32'h00,0);
        add_vec(0,0,32'h0,  1,32'hA5A5A5A5, 1,32'h000,0,32'h0,        32'h00,0);
        add_vec(0,0,32'h0,  0,32'h0,        1,32'h004,1,32'hA5A5A5A5, 32'h04,0);
        add_vec(0,0,32'h0,  1,32'hA5A5A5A1, 1,32'h004,0,32'h0,        32'h00,0);
        add_vec(0,0,32'h0,  0,32'h0,        1,32'h008,1,32'hA5A5A5A1, 32'h08,0);
        add_vec(0,0,32'h0,  1,32'hA5A5A5AD, 1,32'h008,0,32'h0,        32'h00,0);
        add_vec(1,0,32'h0,  0,32'h0,        1,32'h00C,1,32'hA5A5A5AD, 32'h0C,0);
        add_vec(1,0,32'h0,  1,32'hA5A5A5A9, 1,32'h00C,1,32'hA5A5A5AD, 32'h0C,0);
        add_vec(0,0,32'h0,  0,32'h0,        1,32'h010,1,32'hA5A5A5AD, 32'h0C,0);
        add_vec(0,0,32'h0,  1,32'hA5A5A5B5, 1,32'h010,1,32'hA5A5A5A9, 32'h10,0);
        add_vec(0,0,32'h0,  0,32'h0,        1,32'h014,1,32'hA5A5A5B5, 32'h14,0);
        add_vec(0,1,32'h203,0,32'h0,        1,32'h014,0,32'h0,        32'h00,1);
        add_vec(0,0,32'h0,  1,32'hDEADBEEF, 1,32'h014,0,32'h0,        32'h00,0);
        add_vec(0,0,32'h0,  0,32'h0,        0,32'h014,0,32'h0,        32'h00,0);
        add_vec(0,0,32'h0,  0,32'h0,        1,32'h200,0,32'h0,        32'h00,0);

        // Reset values while held in reset.
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_flush", flush, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_bubble_count", bubble_count, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vq[i]) begin
            stall = vq[i].stall; redirect = vq[i].redir; redirect_pc = vq[i].rpc;
            imem_ack = vq[i].ack; imem_data = vq[i].data;
            #2;
            chk($sformatf("vec%0d_req", i),   imem_req,    vq[i].e_req);
            chk($sformatf("vec%0d_addr", i),  imem_addr,   vq[i].e_addr);
            chk($sformatf("vec%0d_valid", i), instr_valid, vq[i].e_valid);
            chk($sformatf("vec%0d_instr", i), instr_out,   vq[i].e_instr);
            chk($sformatf("vec%0d_pc", i),    pc_out,      vq[i].e_pc);
            chk($sformatf("vec%0d_flush", i), flush,       vq[i].e_flush);
            @(posedge clk); #1;
        end
        stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; redirect_pc = '0;

        // Long stall: FIFO fills to DEPTH, then requests stop; release drains in order.
        ack_prev = 1'b0;
        run_auto(10, 1'b1);
        chk("stall_full_req_idle", imem_req, 0);
        chk("stall_full_count", exp_q.size(), 4);
        n_pops = 0;
        run_auto(12, 1'b0);
        chk("stall_release_pops", (n_pops >= 4) ? 1 : 0, 1);

        // Redirect coincident with Ack while the FIFO holds entries.
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (imem_req && !ack_prev && exp_q.size() != 0) begin
                found = 1'b1;
                break;
            end
            run_auto(1, 1'b1);
        end
        chk("redir_ack_setup", found, 1);
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        imem_ack = 1'b1; imem_data = 32'h1234_5678;
        #2;
        chk("redir_ack_flush", flush, 1);
        chk("redir_ack_pre_valid", instr_valid, 1);
        @(posedge clk); #1;
        redirect = 1'b0; imem_ack = 1'b0;
        #1;
        chk("redir_ack_valid", instr_valid, 0);
        chk("redir_ack_instr", instr_out, 0);
        chk("redir_ack_req", imem_req, 0);
        @(posedge clk); #1;
        #1;
        chk("redir_ack_next_req", imem_req, 1);
        chk("redir_ack_next_addr", imem_addr, 32'h0000_0300);
        exp_q.delete();

        // Redirect in WAIT to an unaligned target; wrong-path ack arrives 3 cycles later.
        redirect = 1'b1; redirect_pc = 32'h0000_0103; imem_ack = 1'b0;
        #1;
        chk("discard_flush", flush, 1);
        @(posedge clk); #1;
        redirect = 1'b0;
        #1;
        chk("discard_req_held", imem_req, 1);
        chk("discard_flush_low", flush, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        #1;
        chk("discard_req_at_ack", imem_req, 1);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        #1;
        chk("discard_done_req", imem_req, 0);
        chk("discard_done_valid", instr_valid, 0);
        @(posedge clk); #1;
        #1;
        chk("discard_next_req", imem_req, 1);
        chk("discard_next_addr", imem_addr, 32'h0000_0100);
        ack_prev = 1'b0; seen_bad = 1'b0; n_pops = 0;
        #0;
        @(negedge clk); @(posedge clk); #1;
        exp_q.delete();
        chk("post_discard_empty", instr_valid, 0);
        ack_prev = 1'b0;
        run_auto(16, 1'b0);
        chk("deadbeef_never_seen", seen_bad, 0);
        chk("post_discard_pops", (n_pops >= 3) ? 1 : 0, 1);

        // Asynchronous reset mid-request.
        for (int c = 0; c < 4 && !imem_req; c++) run_auto(1, 1'b0);
        imem_ack = 1'b0;
        #1;
        chk("pre_reset_req", imem_req, 1);
        chk("pre_reset_addr_nonzero", (imem_addr != 0) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_addr", imem_addr, 0);
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_instr", instr_out, 0);
        chk("async_rst_pc", pc_out, 0);
        chk("async_rst_flush", flush, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("async_rst_fetch_count", fetch_count, 0);
        chk("async_rst_bubble_count", bubble_count, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", imem_req, 0);
        @(posedge clk); #1;
        #1;
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 32'h0000_0000);

        // PC wrap instance results.
        chk("wrap_addr_log_len", (w_addr_log.size() >= 3) ? 1 : 0, 1);
        chk("wrap_pc_log_len", (w_pc_log.size() >= 3) ? 1 : 0, 1);
        if (w_addr_log.size() >= 3) begin
            chk("wrap_addr0", w_addr_log[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", w_addr_log[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", w_addr_log[2], 32'h0000_0000);
        end
        if (w_pc_log.size() >= 3) begin
            chk("wrap_pc0", w_pc_log[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", w_pc_log[1], 32'h0000_0000);
            chk("wrap_pc2", w_pc_log[2], 32'h0000_0004);
            chk("wrap_instr1", w_instr_log[1], 32'h5A5A_5A59);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
